// File: rtl/approx_mul_pkg.sv
// Shared definitions for the approximate multiplier family.
//   mode_t   : per-cell approximation mode of a configurable half adder
//   cells()  : number of configurable HA cells for operand width w
//   addr_w() : width of the config address that selects one cell
package approx_mul_pkg;

  typedef enum logic [1:0] {
    MODE_EXACT = 2'b00,  // {c,s} = a + b
    MODE_CARRY = 2'b01,  // c = a, s = 0
    MODE_OR    = 2'b10,  // s = a | b, c = 0
    MODE_ELIM  = 2'b11   // c = s = 0
  } mode_t;

  // W/2 row pairs, W-1 cells per pair.
  function automatic int cells(input int w);
    return (w / 2) * (w - 1);
  endfunction

  function automatic int addr_w(input int w);
    return $clog2(cells(w));
  endfunction

endpackage

// File: rtl/approx_mul_ha_pipe_ha_cell_cfg.sv
// Combinational half adder whose behaviour is chosen at run time.
//   a, b : one-bit operands of equal weight
//   mode : approximation mode (mode_t encoding)
//   s    : sum bit (same weight as a/b)
//   c    : carry bit (one weight higher)
module ha_cell_cfg
  import approx_mul_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [1:0] mode,
  output logic       s,
  output logic       c
);

  always_comb begin
    s = 1'b0;
    c = 1'b0;
    case (mode_t'(mode))
      MODE_EXACT: begin
        s = a ^ b;
        c = a & b;
      end
      // The carry simply forwards a; used when a is known to dominate.
      MODE_CARRY: c = a;
      MODE_OR:    s = a | b;
      default: begin
        s = 1'b0;
        c = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/approx_mul_ha_pipe.sv
// Pipelined unsigned approximate multiplier built from a half-adder array.
// Partial-product rows are paired; each pair is compressed by a row of
// run-time configurable half adders, and the compressed arrays are summed
// into a 2W-bit product.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   cfg_we/addr/mode    : write one cell mode (addr = k*(W-1)+j)
//   cfg_ready           : pipeline empty; a write is taken when cfg_we && cfg_ready
//   in_valid/in_ready   : operand handshake (in_x, in_y)
//   out_valid/out_ready : product handshake (out_p)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A producer keeps valid and data stable until the transfer;
// ready may depend combinationally on the consumer's ready, never on valid.
//
// Pipeline: S1 operands -> S2 compressed t/b arrays -> S3 product.
// Each stage advances when it is empty or the next stage can take its
// content, so bubbles collapse and throughput is one operand per cycle.
module approx_mul_ha_pipe
  import approx_mul_pkg::*;
#(
  parameter  int W     = 8,
  localparam int CELLS = cells(W),
  localparam int AW    = addr_w(W)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [1:0]      cfg_mode,
  output logic            cfg_ready,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_x,
  input  logic [W-1:0]    in_y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-1:0]  out_p
);

  localparam int NP = W / 2;
  localparam logic [AW:0] CELLS_V = (AW + 1)'(CELLS);

  // ---------------------------------------------------------------- state
  mode_t            mode_q [CELLS];
  mode_t            mode_d [CELLS];

  logic             v1_q, v1_d;
  logic [W-1:0]     x1_q, x1_d;
  logic [W-1:0]     y1_q, y1_d;

  logic             v2_q, v2_d;
  logic [W:0]       t_q [NP];
  logic [W:0]       t_d [NP];
  logic [W-2:0]     b_q [NP];
  logic [W-2:0]     b_d [NP];

  logic             v3_q, v3_d;
  logic [2*W-1:0]   p_q, p_d;

  // ---------------------------------------------------------------- flow
  logic ready1, ready2, ready3;
  logic in_fire, ld2, ld3, cfg_fire, addr_ok;

  assign ready3   = !v3_q || out_ready;
  assign ready2   = !v2_q || ready3;
  assign ready1   = !v1_q || ready2;

  // A config write owns the cycle: no operand is taken alongside it.
  assign in_ready  = ready1 && !cfg_we;
  assign in_fire   = in_valid && in_ready;
  assign ld2       = v1_q && ready2;
  assign ld3       = v2_q && ready3;

  assign cfg_ready = !v1_q && !v2_q && !v3_q;
  assign addr_ok   = ({1'b0, cfg_addr} < CELLS_V);
  assign cfg_fire  = cfg_we && cfg_ready && addr_ok;

  assign out_valid = v3_q;
  assign out_p     = p_q;

  // ---------------------------------------------------------------- cells
  logic [W-2:0] s_w [NP];
  logic [W-2:0] c_w [NP];

  for (genvar k = 0; k < NP; k++) begin : g_pair
    for (genvar j = 0; j < W - 1; j++) begin : g_cell
      // a = pp[2k][j+1], b = pp[2k+1][j]; both carry weight j+1.
      ha_cell_cfg u_cell (
        .a    (x1_q[2*k] & y1_q[j+1]),
        .b    (x1_q[2*k+1] & y1_q[j]),
        .mode (mode_q[k*(W-1)+j]),
        .s    (s_w[k][j]),
        .c    (c_w[k][j])
      );
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    for (int i = 0; i < CELLS; i++) mode_d[i] = mode_q[i];
    if (cfg_fire) mode_d[cfg_addr] = mode_t'(cfg_mode);
  end

  always_comb begin
    v1_d = v1_q;
    x1_d = x1_q;
    y1_d = y1_q;
    if (ready1) v1_d = in_fire;
    if (in_fire) begin
      x1_d = in_x;
      y1_d = in_y;
    end
  end

  // t holds the top row with the cell sums merged in (weights 0..W);
  // b holds the carries and the lone MSB of the bottom row (weights 2..W).
  always_comb begin
    v2_d = v2_q;
    for (int k = 0; k < NP; k++) begin
      t_d[k] = t_q[k];
      b_d[k] = b_q[k];
    end
    if (ready2) v2_d = v1_q;
    if (ld2) begin
      for (int k = 0; k < NP; k++) begin
        t_d[k] = {c_w[k][W-2], s_w[k], x1_q[2*k] & y1_q[0]};
        b_d[k] = {x1_q[2*k+1] & y1_q[W-1], c_w[k][W-3:0]};
      end
    end
  end

  // Pair k sits at weight 2k in the final product.
  logic [2*W-1:0] sum_w;
  always_comb begin
    logic [2*W-1:0] pv;
    sum_w = '0;
    pv    = '0;
    for (int k = 0; k < NP; k++) begin
      pv    = {{(W-1){1'b0}}, t_q[k]} + ({{(W+1){1'b0}}, b_q[k]} << 2);
      sum_w = sum_w + (pv << (2 * k));
    end
  end

  always_comb begin
    v3_d = v3_q;
    p_d  = p_q;
    if (ready3) v3_d = v2_q;
    if (ld3)    p_d  = sum_w;
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CELLS; i++) mode_q[i] <= MODE_EXACT;
      v1_q <= 1'b0;
      x1_q <= '0;
      y1_q <= '0;
      v2_q <= 1'b0;
      for (int k = 0; k < NP; k++) begin
        t_q[k] <= '0;
        b_q[k] <= '0;
      end
      v3_q <= 1'b0;
      p_q  <= '0;
    end else begin
      for (int i = 0; i < CELLS; i++) mode_q[i] <= mode_d[i];
      v1_q <= v1_d;
      x1_q <= x1_d;
      y1_q <= y1_d;
      v2_q <= v2_d;
      for (int k = 0; k < NP; k++) begin
        t_q[k] <= t_d[k];
        b_q[k] <= b_d[k];
      end
      v3_q <= v3_d;
      p_q  <= p_d;
    end
  end

endmodule
